// File: rtl/exu_disp_pkg.sv
// Shared types and constants for the execute dispatch/collect stage.
package exu_disp_pkg;
  localparam int CAL_OPB_SIZE = 8;
  localparam int FU_ALU = 0;
  localparam int FU_BJU = 1;
  localparam int FU_AGU = 2;

  typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} disp_st_e;
endpackage

// File: rtl/exu_rr_arb.sv
// Round-robin arbiter with grant lock: a grant is frozen until its handshake.
module exu_rr_arb #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_done,
  output logic [N-1:0] o_gnt,
  output logic         o_val
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_ptr, r_idx;
  logic [N-1:0]  r_gnt;
  logic          r_lock;
  logic [N-1:0]  w_pick;
  logic [IW-1:0] w_pick_idx, w_gidx;
  logic          w_found;

  // First requester at/after the pointer, wrapping to 0.
  always_comb begin
    int j;
    w_pick     = '0;
    w_pick_idx = '0;
    w_found    = 1'b0;
    j          = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(r_ptr) + i;
      if (j >= N) j = j - N;
      if (!w_found && i_req[j]) begin
        w_found    = 1'b1;
        w_pick[j]  = 1'b1;
        w_pick_idx = IW'(j);
      end
    end
  end

  assign o_gnt  = r_lock ? r_gnt : w_pick;
  assign w_gidx = r_lock ? r_idx : w_pick_idx;
  assign o_val  = |o_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_idx  <= '0;
      r_gnt  <= '0;
      r_lock <= 1'b0;
    end else if (o_val && i_done) begin
      r_ptr  <= (w_gidx == IW'(N-1)) ? '0 : w_gidx + 1'b1;
      r_lock <= 1'b0;
    end else if (o_val) begin
      r_lock <= 1'b1;
      r_gnt  <= o_gnt;
      r_idx  <= w_gidx;
    end
  end
endmodule

// File: rtl/exu_disp.sv
// Execute dispatch/collect: issues to one of NFU units, arbitrates the shared
// calculator, and registers the selected result into a valid/ready writeback stage.
module exu_disp
  import exu_disp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NFU  = 3,
  parameter int CALW = CAL_OPB_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_val,
  output logic                hs_ex4rd_rdy,
  input  logic [NFU-1:0]      i_usele,
  input  logic                i_deilg,
  output logic [NFU-1:0]      o_fu_val,
  input  logic [NFU-1:0]      i_fu_rdy,
  input  logic [NFU*XLEN-1:0] i_fu_res,
  input  logic [NFU-1:0]      i_fu_misal,
  input  logic [NFU-1:0]      i_cal_req,
  input  logic [NFU*CALW-1:0] i_cal_opb,
  output logic [NFU-1:0]      o_cal_rdy,
  output logic                o_cal_val,
  output logic [CALW-1:0]     o_cal_opb,
  input  logic                i_cal_done,
  output logic                o_wb_val,
  input  logic                i_wb_rdy,
  output logic [XLEN-1:0]     o_wb_rd,
  output logic                o_wb_ilg,
  output logic [NFU-1:0]      o_wb_fu
);
  disp_st_e        r_st, w_nst;
  logic [NFU-1:0]  r_sel;
  logic            r_wb_val, r_wb_ilg;
  logic [XLEN-1:0] r_wb_rd;
  logic [NFU-1:0]  r_wb_fu;
  logic            w_out_free, w_onehot, w_done, w_ilg_done, w_misal;
  logic [XLEN-1:0] w_res;
  logic [NFU-1:0]  w_cal_gnt;

  assign w_out_free = ~r_wb_val | i_wb_rdy;
  assign w_onehot   = (i_usele != '0) && ((i_usele & (i_usele - NFU'(1))) == '0);

  always_comb begin
    w_nst      = r_st;
    o_fu_val   = '0;
    w_done     = 1'b0;
    w_ilg_done = 1'b0;
    case (r_st)
      S_IDLE: begin
        if (i_val) begin
          if (w_onehot) begin
            o_fu_val = i_usele;
            w_done   = (|(i_usele & i_fu_rdy)) & w_out_free;
            if (!w_done) w_nst = S_EXEC;
          end else begin
            // Bad select starts nothing; it retires as an illegal op.
            w_ilg_done = w_out_free;
          end
        end
      end
      S_EXEC: begin
        o_fu_val = r_sel;
        w_done   = (|(r_sel & i_fu_rdy)) & w_out_free;
        if (w_done) w_nst = S_IDLE;
      end
      default: w_nst = S_IDLE;
    endcase
  end

  assign hs_ex4rd_rdy = w_done | w_ilg_done;

  always_comb begin
    w_res   = '0;
    w_misal = 1'b0;
    for (int k = 0; k < NFU; k++) begin
      if (o_fu_val[k]) begin
        w_res   = w_res | i_fu_res[k*XLEN +: XLEN];
        w_misal = w_misal | i_fu_misal[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st     <= S_IDLE;
      r_sel    <= '0;
      r_wb_val <= 1'b0;
      r_wb_rd  <= '0;
      r_wb_ilg <= 1'b0;
      r_wb_fu  <= '0;
    end else begin
      r_st <= w_nst;
      if (r_st == S_IDLE && w_nst == S_EXEC) r_sel <= i_usele;
      if (hs_ex4rd_rdy) begin
        r_wb_val <= 1'b1;
        r_wb_rd  <= w_ilg_done ? '0 : w_res;
        r_wb_ilg <= w_ilg_done | w_misal | i_deilg;
        r_wb_fu  <= w_ilg_done ? '0 : o_fu_val;
      end else if (i_wb_rdy) begin
        r_wb_val <= 1'b0;
      end
    end
  end

  assign o_wb_val = r_wb_val;
  assign o_wb_rd  = r_wb_rd;
  assign o_wb_ilg = r_wb_ilg;
  assign o_wb_fu  = r_wb_fu;

  exu_rr_arb #(.N(NFU)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (i_cal_req),
    .i_done(i_cal_done),
    .o_gnt (w_cal_gnt),
    .o_val (o_cal_val)
  );

  assign o_cal_rdy = w_cal_gnt & {NFU{i_cal_done}};

  always_comb begin
    o_cal_opb = '0;
    for (int k = 0; k < NFU; k++)
      if (w_cal_gnt[k]) o_cal_opb = o_cal_opb | i_cal_opb[k*CALW +: CALW];
  end
endmodule

// File: tb/tb_exu_disp.sv
// Bench for exu_disp: directed scenarios plus randomized traffic against a queue model.
module tb_exu_disp;
  localparam int XLEN = 32, NFU = 3, CALW = 8;

  logic clk = 1'b0, rst;
  logic i_val, hs_ex4rd_rdy, i_deilg, o_cal_val, i_cal_done, o_wb_val, i_wb_rdy, o_wb_ilg;
  logic [NFU-1:0] i_usele, o_fu_val, i_fu_rdy, i_fu_misal, i_cal_req, o_cal_rdy, o_wb_fu;
  logic [NFU*XLEN-1:0] i_fu_res;
  logic [NFU*CALW-1:0] i_cal_opb;
  logic [CALW-1:0] o_cal_opb;
  logic [XLEN-1:0] o_wb_rd;

  int n_cmp = 0, n_err = 0;

  typedef struct {logic [XLEN-1:0] rd; logic ilg; logic [NFU-1:0] fu;} exp_t;
  exp_t q[$];

  exu_disp #(.XLEN(XLEN), .NFU(NFU), .CALW(CALW)) dut (
    .clk(clk), .rst(rst), .i_val(i_val), .hs_ex4rd_rdy(hs_ex4rd_rdy), .i_usele(i_usele),
    .i_deilg(i_deilg), .o_fu_val(o_fu_val), .i_fu_rdy(i_fu_rdy), .i_fu_res(i_fu_res),
    .i_fu_misal(i_fu_misal), .i_cal_req(i_cal_req), .i_cal_opb(i_cal_opb),
    .o_cal_rdy(o_cal_rdy), .o_cal_val(o_cal_val), .o_cal_opb(o_cal_opb),
    .i_cal_done(i_cal_done), .o_wb_val(o_wb_val), .i_wb_rdy(i_wb_rdy), .o_wb_rd(o_wb_rd),
    .o_wb_ilg(o_wb_ilg), .o_wb_fu(o_wb_fu)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    i_val = 0; i_usele = '0; i_deilg = 0; i_fu_rdy = '0; i_fu_res = '0; i_fu_misal = '0;
    i_cal_req = '0; i_cal_opb = '0; i_cal_done = 0; i_wb_rdy = 1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({o_wb_val, o_fu_val, o_cal_val, o_wb_rd, o_wb_ilg, o_wb_fu, hs_ex4rd_rdy} !== '0) begin
      n_err++;
      $display("FAIL reset_state: wb_val=%b fu_val=%b cal_val=%b rd=%h ilg=%b fu=%b hs=%b want all 0",
               o_wb_val, o_fu_val, o_cal_val, o_wb_rd, o_wb_ilg, o_wb_fu, hs_ex4rd_rdy);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    i_val = 1; i_usele = 3'b001; i_fu_rdy = 3'b001; i_fu_res[31:0] = 32'h1234; i_wb_rdy = 1;
    @(negedge clk);
    n_cmp++;
    if (hs_ex4rd_rdy !== 1'b1 || o_fu_val !== 3'b001) begin
      n_err++; $display("FAIL single_hs: hs=%b fu_val=%b want 1/001", hs_ex4rd_rdy, o_fu_val);
    end
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (o_wb_val !== 1 || o_wb_rd !== 32'h1234 || o_wb_fu !== 3'b001 || o_wb_ilg !== 0) begin
      n_err++; $display("FAIL single_wb: val=%b rd=%h fu=%b ilg=%b want 1/1234/001/0",
                        o_wb_val, o_wb_rd, o_wb_fu, o_wb_ilg);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (o_wb_val !== 1'b0) begin
      n_err++; $display("FAIL single_drain: wb_val=%b want 0", o_wb_val);
    end
  endtask

  task automatic test_illegal();
    @(posedge clk); #1;
    i_val = 1; i_usele = 3'b011; i_fu_rdy = 3'b011; i_fu_res = '1;
    @(negedge clk);
    n_cmp++;
    if (o_fu_val !== 3'b000 || hs_ex4rd_rdy !== 1'b1) begin
      n_err++; $display("FAIL illegal_issue: fu_val=%b hs=%b want 000/1", o_fu_val, hs_ex4rd_rdy);
    end
    @(posedge clk); #1;
    i_usele = 3'b100; i_fu_rdy = 3'b100; i_fu_misal = 3'b100; i_fu_res = '0;
    i_fu_res[95:64] = 32'h55;
    @(negedge clk);
    n_cmp++;
    if (o_wb_val !== 1 || o_wb_ilg !== 1 || o_wb_rd !== '0 || o_wb_fu !== 3'b000) begin
      n_err++; $display("FAIL illegal_wb: val=%b ilg=%b rd=%h fu=%b want 1/1/0/000",
                        o_wb_val, o_wb_ilg, o_wb_rd, o_wb_fu);
    end
    n_cmp++;
    if (hs_ex4rd_rdy !== 1'b1) begin
      n_err++; $display("FAIL misal_hs: hs=%b want 1", hs_ex4rd_rdy);
    end
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (o_wb_ilg !== 1 || o_wb_rd !== 32'h55 || o_wb_fu !== 3'b100) begin
      n_err++; $display("FAIL misal_wb: ilg=%b rd=%h fu=%b want 1/55/100", o_wb_ilg, o_wb_rd, o_wb_fu);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    i_wb_rdy = 0; i_val = 1; i_usele = 3'b001; i_fu_rdy = 3'b001; i_fu_res[31:0] = 32'hA1;
    @(negedge clk);
    @(posedge clk); #1;
    i_usele = 3'b010; i_fu_rdy = 3'b010; i_fu_res = '0; i_fu_res[63:32] = 32'hB2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (hs_ex4rd_rdy !== 0 || o_fu_val !== 3'b010 || o_wb_val !== 1 || o_wb_rd !== 32'hA1) begin
        n_err++; $display("FAIL bp_hold[%0d]: hs=%b fu_val=%b wb_val=%b rd=%h want 0/010/1/a1",
                          c, hs_ex4rd_rdy, o_fu_val, o_wb_val, o_wb_rd);
      end
      @(posedge clk); #1;
    end
    i_wb_rdy = 1;
    @(negedge clk);
    n_cmp++;
    if (hs_ex4rd_rdy !== 1'b1) begin
      n_err++; $display("FAIL bp_release: hs=%b want 1", hs_ex4rd_rdy);
    end
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (o_wb_val !== 1 || o_wb_rd !== 32'hB2 || o_wb_fu !== 3'b010) begin
      n_err++; $display("FAIL bp_wb: val=%b rd=%h fu=%b want 1/b2/010", o_wb_val, o_wb_rd, o_wb_fu);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    i_wb_rdy = 0; i_val = 1; i_usele = 3'b001; i_fu_rdy = 3'b001;
    @(posedge clk); #1;
    i_usele = 3'b100; i_fu_rdy = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (o_fu_val !== 3'b100 || o_wb_val !== 1'b1) begin
      n_err++; $display("FAIL mid_pre: fu_val=%b wb_val=%b want 100/1", o_fu_val, o_wb_val);
    end
    #1 rst = 1; i_val = 0;
    #1;
    n_cmp++;
    if (o_fu_val !== 3'b000 || o_wb_val !== 1'b0) begin
      n_err++; $display("FAIL mid_rst: fu_val=%b wb_val=%b want 000/0", o_fu_val, o_wb_val);
    end
    @(posedge clk); #1 rst = 0; i_val = 1; i_usele = 3'b010; i_wb_rdy = 1;
    @(negedge clk);
    n_cmp++;
    if (o_fu_val !== 3'b010) begin
      n_err++; $display("FAIL mid_restart: fu_val=%b want 010", o_fu_val);
    end
    @(posedge clk); #1 i_fu_rdy = 3'b010;
    @(posedge clk); #1 idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_arbiter();
    logic [CALW-1:0] opb [NFU];
    int exp_g [4];
    opb[0] = 8'hA0; opb[1] = 8'hB1; opb[2] = 8'hC2;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      i_cal_req = 3'b111; i_cal_opb = {opb[2], opb[1], opb[0]};
      i_cal_done = (c % 3 == 2);
      @(negedge clk);
      n_cmp++;
      if (o_cal_val !== 1 || o_cal_opb !== opb[exp_g[c/3]] ||
          o_cal_rdy !== (i_cal_done ? NFU'(1) << exp_g[c/3] : NFU'(0))) begin
        n_err++; $display("FAIL arb_rr[%0d]: val=%b opb=%h rdy=%b want grantee %0d", c,
                          o_cal_val, o_cal_opb, o_cal_rdy, exp_g[c/3]);
      end
    end
  endtask

  task automatic test_arb_random(input int start_ptr);
    int ptr, cur, j;
    logic [NFU-1:0] exp_rdy;
    logic [CALW-1:0] exp_opb;
    ptr = start_ptr; cur = -1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      i_cal_req = NFU'($urandom) | ((cur >= 0) ? NFU'(1) << cur : NFU'(0));
      i_cal_opb = NFU*CALW'($urandom);
      i_cal_done = ($urandom % 3) == 0;
      @(negedge clk);
      if (cur < 0)
        for (int i = 0; i < NFU; i++) begin
          j = (ptr + i) % NFU;
          if (cur < 0 && i_cal_req[j]) cur = j;
        end
      exp_opb = (cur >= 0) ? i_cal_opb[cur*CALW +: CALW] : '0;
      exp_rdy = (cur >= 0 && i_cal_done) ? NFU'(1) << cur : '0;
      n_cmp++;
      if (o_cal_val !== (cur >= 0) || o_cal_opb !== exp_opb || o_cal_rdy !== exp_rdy) begin
        n_err++; $display("FAIL arb_rand[%0d]: val=%b opb=%h rdy=%b want %b/%h/%b", c,
                          o_cal_val, o_cal_opb, o_cal_rdy, cur >= 0, exp_opb, exp_rdy);
      end
      if (cur >= 0 && i_cal_done) begin ptr = (cur + 1) % NFU; cur = -1; end
    end
    @(posedge clk); #1 idle_inputs();
  endtask

  task automatic test_back_to_back();
    bit have, legal, misal, deilg;
    logic [NFU-1:0] sel, exp_fv;
    logic [XLEN-1:0] res;
    int delay, idx, n_done;
    bit exp_hs;
    exp_t e;
    have = 0; n_done = 0; delay = 0; idx = 0; sel = '0; legal = 0;
    res = '0; misal = 0; deilg = 0;
    for (int c = 0; c < 3000 && n_done < 80; c++) begin
      @(posedge clk); #1;
      i_wb_rdy = ($urandom % 4) != 0;
      if (!have && ($urandom % 4) != 0) begin
        have = 1;
        sel = (($urandom % 8) < 6) ? NFU'(1) << ($urandom % NFU) : NFU'($urandom);
        legal = $countones(sel) == 1;
        res = $urandom; misal = ($urandom % 5) == 0; deilg = ($urandom % 8) == 0;
        delay = $urandom % 4;
        for (int k = 0; k < NFU; k++) if (sel[k]) idx = k;
      end
      i_val = have; i_usele = have ? sel : NFU'($urandom); i_deilg = deilg;
      i_fu_res = {$urandom, $urandom, $urandom}; i_fu_misal = NFU'($urandom);
      i_fu_rdy = NFU'($urandom);
      if (have && legal) begin
        i_fu_rdy[idx] = (delay == 0);
        i_fu_res[idx*XLEN +: XLEN] = res;
        i_fu_misal[idx] = misal;
      end
      @(negedge clk);
      if (o_wb_val && i_wb_rdy) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL b2b_spurious: wb rd=%h with nothing expected", o_wb_rd);
        end else begin
          e = q.pop_front();
          if (o_wb_rd !== e.rd || o_wb_ilg !== e.ilg || o_wb_fu !== e.fu) begin
            n_err++; $display("FAIL b2b_wb: rd=%h ilg=%b fu=%b want %h/%b/%b",
                              o_wb_rd, o_wb_ilg, o_wb_fu, e.rd, e.ilg, e.fu);
          end
        end
      end
      exp_fv = (have && legal) ? sel : '0;
      exp_hs = have && (!legal || delay == 0) && (!o_wb_val || i_wb_rdy);
      n_cmp++;
      if (o_fu_val !== exp_fv || hs_ex4rd_rdy !== exp_hs) begin
        n_err++; $display("FAIL b2b_issue[%0d]: fu_val=%b hs=%b want %b/%b",
                          c, o_fu_val, hs_ex4rd_rdy, exp_fv, exp_hs);
      end
      if (exp_hs) begin
        e.rd  = legal ? res : '0;
        e.ilg = !legal || misal || deilg;
        e.fu  = legal ? sel : '0;
        q.push_back(e);
        have = 0; n_done++;
      end else if (have && delay > 0) begin
        delay--;
      end
    end
    @(posedge clk); #1 idle_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (o_wb_val && q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (o_wb_rd !== e.rd || o_wb_ilg !== e.ilg || o_wb_fu !== e.fu) begin
          n_err++; $display("FAIL b2b_drain: rd=%h ilg=%b fu=%b want %h/%b/%b",
                            o_wb_rd, o_wb_ilg, o_wb_fu, e.rd, e.ilg, e.fu);
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (q.size() != 0 || n_done < 80) begin
      n_err++; $display("FAIL b2b_count: left=%0d retired=%0d want 0/80", q.size(), n_done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_arbiter();
    test_arb_random(1);
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
